// File: rtl/instr_fetch_if.sv
// Fetch-side bus: instruction ROM port, execute redirect, and the decode handshake.
// Handshake: an instruction transfers on a cycle where instr_valid && instr_ready at the rising edge; instr/instr_pc are stable while instr_valid is high and not yet accepted.
interface instr_fetch_if #(
    parameter int AW = 10
);
    logic [AW-1:0] rom_address;
    logic [9:0]    rom_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          instr_valid;
    logic          instr_ready;
    logic [9:0]    instr;
    logic [AW-1:0] instr_pc;
    logic          halted;

    modport master (
        output rom_address,
        input  rom_data,
        input  redirect_valid,
        input  redirect_addr,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output halted
    );

    modport slave (
        input  rom_address,
        output rom_data,
        output redirect_valid,
        output redirect_addr,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC, jump folding, halt detection, redirect flush and a small in-order buffer to decode.
// Optional macro FETCH_JUMP_FOLD_EN: jump words are consumed in fetch instead of being pushed to decode.
module instr_fetch #(
    parameter int            AW       = 10,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int            DEPTH    = 2
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus,
    output logic           dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [9:0] HALT_WORD = 10'b0010000010;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [9:0]    last_word_q, last_word_d;
    logic [AW-1:0] last_pc_q, last_pc_d;

    logic [9:0]    buf_word_q [DEPTH];
    logic [AW-1:0] buf_pc_q   [DEPTH];

    logic pop;
    logic fetch;
    logic push;
    logic is_jump;
    logic is_halt;

    assign bus.rom_address = pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.halted      = (state_q == HALTED);
    assign dbg_state       = state_q;
    // An empty buffer keeps showing the most recent head rather than stale slot contents.
    assign bus.instr       = bus.instr_valid ? buf_word_q[rd_ptr_q] : last_word_q;
    assign bus.instr_pc    = bus.instr_valid ? buf_pc_q[rd_ptr_q]   : last_pc_q;

    always_comb begin
        pop     = bus.instr_valid && bus.instr_ready;
        is_jump = (bus.rom_data[9:6] == 4'b1000);
        is_halt = (bus.rom_data == HALT_WORD);
        fetch   = (state_q == RUN) && ((count_q < CW'(DEPTH)) || pop) && !bus.redirect_valid;
`ifdef FETCH_JUMP_FOLD_EN
        push    = fetch && !is_jump;
`else
        push    = fetch;
`endif

        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        last_word_d = last_word_q;
        last_pc_d   = last_pc_q;

        if (bus.instr_valid) begin
            last_word_d = buf_word_q[rd_ptr_q];
            last_pc_d   = buf_pc_q[rd_ptr_q];
        end

        if (bus.redirect_valid) begin
            // Redirect overrides everything: flush, retarget, leave HALTED.
            state_d  = RUN;
            pc_d     = bus.redirect_addr;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (fetch) begin
                if (is_halt) begin
                    state_d = HALTED;
                end else if (is_jump) begin
                    pc_d = AW'(bus.rom_data[5:0]);
                end else begin
                    pc_d = pc_q + AW'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            last_word_q <= '0;
            last_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            last_word_q <= last_word_d;
            last_pc_q   <= last_pc_d;
        end
    end

    // Storage needs no reset: count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_word_q[wr_ptr_q] <= bus.rom_data;
            buf_pc_q[wr_ptr_q]   <= pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed program with literal checkpoints plus a queue-based program-order model checked every cycle.
module tb_instr_fetch;
    localparam int AW    = 10;
    localparam int DEPTH = 2;
    localparam logic [9:0] HALT_WORD = 10'h082;
`ifdef FETCH_JUMP_FOLD_EN
    localparam bit FOLD = 1'b1;
`else
    localparam bit FOLD = 1'b0;
`endif

    logic clk;
    logic rst;
    logic dbg_state;
    logic [9:0] rom [1024];

    instr_fetch_if #(.AW(AW)) bus ();

    instr_fetch #(.AW(AW), .RESET_PC('0), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    assign bus.rom_data = rom[bus.rom_address];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected program-order stream: {word, pc}
    logic [9+AW:0] exp_q[$];
    logic [AW-1:0] m_pc;
    logic          m_halt;
    logic [9:0]    m_last_word;
    logic [AW-1:0] m_last_pc;
    bit            model_live = 0;

    always @(posedge clk) begin
        logic       do_pop;
        logic       do_fetch;
        logic [9:0] w;
        if (rst) begin
            exp_q.delete();
            m_pc        = '0;
            m_halt      = 1'b0;
            m_last_word = '0;
            m_last_pc   = '0;
            model_live  = 1;
        end else if (model_live) begin
            do_pop = (exp_q.size() > 0) && bus.instr_ready;
            if (exp_q.size() > 0 && (do_pop || bus.redirect_valid)) begin
                m_last_word = exp_q[0][9+AW:AW];
                m_last_pc   = exp_q[0][AW-1:0];
            end
            if (bus.redirect_valid) begin
                exp_q.delete();
                m_pc   = bus.redirect_addr;
                m_halt = 1'b0;
            end else begin
                do_fetch = !m_halt && (exp_q.size() < DEPTH || do_pop);
                if (do_pop) void'(exp_q.pop_front());
                if (do_fetch) begin
                    w = rom[m_pc];
                    if (!(FOLD && w[9:6] == 4'b1000)) exp_q.push_back({w, m_pc});
                    if (w == HALT_WORD) m_halt = 1'b1;
                    else if (w[9:6] == 4'b1000) m_pc = {4'b0, w[5:0]};
                    else m_pc = m_pc + 10'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("rom_address", bus.rom_address, m_pc);
            check("halted", bus.halted, m_halt);
            check("dbg_state", dbg_state, m_halt);
            check("instr_valid", bus.instr_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("instr", bus.instr, exp_q[0][9+AW:AW]);
                check("instr_pc", bus.instr_pc, exp_q[0][AW-1:0]);
            end else begin
                check("instr_hold", bus.instr, m_last_word);
                check("instr_pc_hold", bus.instr_pc, m_last_pc);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic redirect_pulse(input logic [AW-1:0] addr);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = addr;
        @(negedge clk);
        #1;
        bus.redirect_valid = 1'b0;
    endtask

    logic [15:0] ready_pat;
    bit          seen_halt;

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = {4'b0001, 6'(i)};
        rom[0]  = 10'h000;
        rom[1]  = 10'h370;
        rom[2]  = 10'h36D;
        rom[7]  = 10'b1000001001;
        rom[47] = HALT_WORD;

        rst                = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and straight-line delivery
        cyc(1);
        check("rst rom_address", bus.rom_address, 0);
        check("rst instr_valid", bus.instr_valid, 0);
        check("rst halted", bus.halted, 0);
        check("rst instr", bus.instr, 0);
        check("rst instr_pc", bus.instr_pc, 0);
        cyc(1);
        check("sl addr1", bus.rom_address, 1);
        check("sl word0", bus.instr, 10'h000);
        check("sl pc0", bus.instr_pc, 0);
        check("sl valid0", bus.instr_valid, 1);
        cyc(1);
        check("sl addr2", bus.rom_address, 2);
        check("sl word1", bus.instr, 10'h370);
        check("sl pc1", bus.instr_pc, 1);
        cyc(1);
        check("sl addr3", bus.rom_address, 3);
        check("sl word2", bus.instr, 10'h36D);
        check("sl pc2", bus.instr_pc, 2);

        // Jump at 7 -> 9
        cyc(4);
        check("jmp addr7", bus.rom_address, 7);
        check("jmp pc6", bus.instr_pc, 6);
        cyc(1);
        check("jmp target addr", bus.rom_address, 9);
`ifdef FETCH_JUMP_FOLD_EN
        check("fold bubble valid", bus.instr_valid, 0);
        check("fold hold pc", bus.instr_pc, 6);
`else
        check("nofold jump pc", bus.instr_pc, 7);
        check("nofold jump word", bus.instr, 10'h209);
`endif
        cyc(1);
        check("jmp pc9", bus.instr_pc, 9);
        check("jmp addr10", bus.rom_address, 10);

        // Backpressure for 5 cycles
        #1 bus.instr_ready = 1'b0;
        cyc(3);
        check("bp frozen addr", bus.rom_address, 11);
        check("bp head pc", bus.instr_pc, 9);
        cyc(2);
        check("bp still frozen", bus.rom_address, 11);
        #1 bus.instr_ready = 1'b1;
        cyc(1);
        check("bp release pc10", bus.instr_pc, 10);
        check("bp release addr", bus.rom_address, 12);
        cyc(1);
        check("bp release pc11", bus.instr_pc, 11);

        // Redirect with two entries buffered
        redirect_pulse(10'd35);
        check("rd flush valid", bus.instr_valid, 0);
        check("rd addr35", bus.rom_address, 35);
        cyc(1);
        check("rd first valid", bus.instr_valid, 1);
        check("rd first pc", bus.instr_pc, 35);

        // Run into halt at 47
        seen_halt = 0;
        for (int i = 0; i < 40 && !seen_halt; i++) begin
            cyc(1);
            seen_halt = bus.halted;
        end
        check("halt reached", seen_halt, 1);
        check("halt word", bus.instr, HALT_WORD);
        check("halt pc", bus.instr_pc, 47);
        cyc(4);
        check("halt addr stays", bus.rom_address, 47);
        check("halt no fetch", bus.instr_valid, 0);
        check("halt held", bus.halted, 1);

        redirect_pulse(10'd3);
        check("unhalt", bus.halted, 0);
        check("unhalt addr", bus.rom_address, 3);
        cyc(1);
        check("resume pc3", bus.instr_pc, 3);

        // PC wrap
        redirect_pulse(10'd1020);
        cyc(3);
        check("wrap addr1023", bus.rom_address, 1023);
        cyc(1);
        check("wrap addr0", bus.rom_address, 0);
        check("wrap pc1023", bus.instr_pc, 1023);
        cyc(1);
        check("wrap pc0", bus.instr_pc, 0);

        // Reset while full and stalled
        #1 bus.instr_ready = 1'b0;
        cyc(3);
        check("stall full", bus.instr_valid, 1);
        #1 rst = 1'b1;
        cyc(1);
        check("mid rst addr", bus.rom_address, 0);
        check("mid rst valid", bus.instr_valid, 0);
        check("mid rst instr", bus.instr, 0);
        check("mid rst pc", bus.instr_pc, 0);
        #1;
        rst = 1'b0;
        bus.instr_ready = 1'b1;

        // Irregular decode stalls plus a redirect, checked by the model
        ready_pat = 16'b1011_0010_1110_0101;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            #1 bus.instr_ready = ready_pat[i];
        end
        redirect_pulse(10'd40);
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            #1 bus.instr_ready = ready_pat[15-i];
        end
        #1 bus.instr_ready = 1'b1;
        cyc(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 10-bit single-cycle/multicycle core. It drives the address port of the instruction ROM, captures the combinationally returned word, and delivers instructions in program order to decode through a valid/ready handshake. A 2-entry buffer decouples decode stalls from fetch. The unit folds unconditional jumps locally, stops at the halt word, and accepts taken-branch redirects from execute.

## Interface
- `AW`, 10: ROM address / PC width.
- `RESET_PC`, 0: first fetch address after reset. Address 0 holds the reset-timing NOP.
- `DEPTH`, 2: instruction buffer entries (power of two, ≥2).
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rom_address` out AW: ROM read address; always equals the current PC.
- `rom_data` in 10: ROM word at `rom_address`, valid in the same cycle.
- `redirect_valid` in 1: taken branch from execute.
- `redirect_addr` in AW: branch target.
- `instr_valid` out 1: buffer head valid.
- `instr_ready` in 1: decode accepts the head.
- `instr` out 10: head instruction word.
- `instr_pc` out AW: address the head was fetched from.
- `halted` out 1: fetch has stopped on the halt word.

## Operation
- States: RUN and HALTED. Reset enters RUN with PC = RESET_PC and the buffer empty.
- Fetch fires in RUN when `count < DEPTH` or a pop happens in the same cycle, and no redirect is present.
- A fetch pushes {`rom_data`, PC} unless the word is folded (see Configuration).
- After a fetch, the next PC is computed as follows:
  - Jump (`rom_data[9:6] == 4'b1000`): next PC = `{0, rom_data[5:0]}`, zero-extended to AW.
  - Otherwise: next PC = PC+1, wrapping from 2^AW−1 to 0.
- Halt word (`10'b0010000010`): pushed like any other instruction. PC stays on the halt address and the state moves to HALTED. HALTED performs no fetches; `halted` is 1.
- Redirect (`redirect_valid`=1):
  - Flushes all buffer entries.
  - Sets PC = `redirect_addr` and forces the state to RUN, which also clears HALTED.
  - Blocks any push that cycle.
  - Redirect takes priority over a simultaneous fetch and pop. The pop still counts as a handshake, but the flushed data is discarded.
- Pop occurs when `instr_valid && instr_ready`. The head advances in order.
- Buffer full and no pop: fetch stalls and PC holds.
- Buffer empty: `instr_valid`=0, and `instr`/`instr_pc` hold their last values.
- Asserting `rst` in any state, mid-stream or mid-stall, discards everything on that edge.

## Timing
- Reset values:
  - `instr_valid`=0, `instr`=0, `instr_pc`=0, `halted`=0.
  - `rom_address`=RESET_PC.
- Fetch-to-decode latency:
  - A word fetched in cycle N is visible at `instr_valid` in cycle N+1 (registered buffer).
  - No bypass path exists.
- Redirect at cycle N:
  - `rom_address` = `redirect_addr` in N+1.
  - First new instruction valid in N+2.
- Jump fetched in cycle N: `rom_address` = target in N+1, giving zero bubble cycles at the fetch port.
- Sustained throughput: one instruction per cycle while `instr_ready`=1.
- `halted` rises the cycle after the halt word is fetched.

## Configuration
- `FETCH_JUMP_FOLD_EN` defined:
  - Jump words are consumed in fetch and never pushed.
  - Decode sees the target instruction directly after the instruction preceding the jump.
- Undefined:
  - Jump words are pushed into the buffer with their PC. Decode/execute treat them as no-ops.
  - The fetch-side PC redirect still occurs.

## Test plan
- **Reset and straight-line:**
  - Stimulus: ROM[0..2] = 0, 0x370, 0x36D; `instr_ready`=1; release `rst`.
  - Required: `rom_address` reads 0,1,2 on consecutive cycles; `instr`/`instr_pc` read (0x000,0),(0x370,1),(0x36D,2) starting one cycle later.
- **Jump fold:**
  - Stimulus: ROM[7] = 10'b1000001001.
  - With `FETCH_JUMP_FOLD_EN`: `rom_address` goes 7 → 9 and the delivered `instr_pc` sequence is 6,9.
  - Without it: the delivered `instr_pc` sequence is 6,7,9.
- **Backpressure:**
  - Stimulus: hold `instr_ready`=0 for 5 cycles.
  - Required: the buffer fills to 2 and `rom_address` freezes at the third address. On release, there is no loss or duplication and order is preserved.
- **Redirect:**
  - Stimulus: with 2 entries buffered, pulse `redirect_valid` with `redirect_addr`=35.
  - Required: `instr_valid`=0 next cycle, `rom_address`=35 next cycle, and `instr_pc`=35 valid the cycle after.
- **Halt:**
  - Stimulus: ROM[47] = 0x082.
  - Required: the halt word is delivered with `instr_pc`=47, `halted`=1, and `rom_address` stays 47 indefinitely.
  - A subsequent redirect to 3 clears `halted` and fetching resumes from 3.
- **Wrap and reset mid-stall:**
  - Stimulus: PC at 1023 with a non-jump word.
  - Required: next `rom_address`=0.
  - Asserting `rst` while full and stalled empties the buffer and `rom_address`=RESET_PC next cycle.
